// File: rtl/ras_recovery_sequencer.sv
// RAS pointer-recovery sequencer: picks the oldest backend recovery by ROB age, issues one
// registered strobe with checkpoint pointers, then stalls fetch-side RAS updates for a lockout.
module ras_recovery_sequencer #(
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned RAS_ENTRY_NUM = 16,
  parameter int unsigned AGE_W         = 7,
  parameter int unsigned LOCK_CYCLES   = 2,
  localparam int unsigned IDX_W        = $clog2(RAS_ENTRY_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AGE_W-1:0]         robHead,
  input  logic                     flushAll,
  input  logic [NUM_SRC-1:0]       srcValid,
  input  logic [NUM_SRC*AGE_W-1:0] srcAge,
  input  logic [NUM_SRC*IDX_W-1:0] srcStackTop,
  input  logic [NUM_SRC*IDX_W-1:0] srcQueueTail,
  output logic [NUM_SRC-1:0]       srcAck,
  output logic                     recoverValid,
  output logic [IDX_W-1:0]         recoverStackTop,
  output logic [IDX_W-1:0]         recoverQueueTail,
  output logic                     fetchStall,
  output logic                     busy,
  output logic [15:0]              dropCount
);

  localparam int unsigned SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CntW = $clog2(LOCK_CYCLES + 2);

  typedef enum logic [1:0] {StIdle, StIssue, StLock} state_e;

  state_e            state_q;
  logic [AGE_W-1:0]  age_q;
  logic              flush_q;
  logic [CntW-1:0]   cnt_q;
  logic              recover_valid_q, fetch_stall_q, busy_q;
  logic [IDX_W-1:0]  top_q, tail_q;
  logic [15:0]       drop_cnt_q;

  logic [AGE_W-1:0]  src_rel [NUM_SRC];
  logic              src_found;
  logic [SrcW-1:0]   src_idx;
  logic [AGE_W-1:0]  src_best_rel;
  logic [AGE_W-1:0]  lat_rel;
  logic              cand_older, accept;
  logic [AGE_W-1:0]  cand_age;
  logic [IDX_W-1:0]  cand_top, cand_tail;
  logic [16:0]       n_valid, n_drop, drop_sum;
  logic [15:0]       drop_cnt_d;

  assign srcAck = srcValid;

  // Oldest valid source; strict compare keeps the lower index on equal age.
  always_comb begin
    src_found    = 1'b0;
    src_idx      = '0;
    src_best_rel = '0;
    n_valid      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_rel[i] = srcAge[i*AGE_W +: AGE_W] - robHead;
      n_valid    = n_valid + 17'(srcValid[i]);
      if (srcValid[i] && (!src_found || src_rel[i] < src_best_rel)) begin
        src_found    = 1'b1;
        src_idx      = SrcW'(i);
        src_best_rel = src_rel[i];
      end
    end
  end

  always_comb begin
    lat_rel   = age_q - robHead;
    cand_age  = flushAll ? robHead : srcAge[src_idx*AGE_W +: AGE_W];
    cand_top  = flushAll ? '0 : srcStackTop[src_idx*IDX_W +: IDX_W];
    cand_tail = flushAll ? '0 : srcQueueTail[src_idx*IDX_W +: IDX_W];
    // A latched flush can only be displaced by nothing; a new flush beats any source.
    if (flushAll) cand_older = !flush_q;
    else          cand_older = src_found && !flush_q && (src_best_rel < lat_rel);
    accept     = (flushAll || src_found) && ((state_q == StIdle) || cand_older);
    n_drop     = n_valid - 17'(accept && !flushAll && src_found);
    drop_sum   = {1'b0, drop_cnt_q} + n_drop;
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      age_q           <= '0;
      flush_q         <= 1'b0;
      cnt_q           <= '0;
      recover_valid_q <= 1'b0;
      fetch_stall_q   <= 1'b0;
      busy_q          <= 1'b0;
      top_q           <= '0;
      tail_q          <= '0;
      drop_cnt_q      <= '0;
    end else begin
      recover_valid_q <= 1'b0;
      drop_cnt_q      <= drop_cnt_d;
      if (accept) begin
        state_q         <= StIssue;
        age_q           <= cand_age;
        flush_q         <= flushAll;
        top_q           <= cand_top;
        tail_q          <= cand_tail;
        recover_valid_q <= 1'b1;
        fetch_stall_q   <= 1'b1;
        busy_q          <= 1'b1;
      end else begin
        unique case (state_q)
          StIssue: begin
            if (LOCK_CYCLES == 0) begin
              state_q       <= StIdle;
              fetch_stall_q <= 1'b0;
              busy_q        <= 1'b0;
            end else begin
              state_q <= StLock;
              cnt_q   <= CntW'(LOCK_CYCLES);
            end
          end
          StLock: begin
            if (cnt_q <= CntW'(1)) begin
              state_q       <= StIdle;
              fetch_stall_q <= 1'b0;
              busy_q        <= 1'b0;
            end
            cnt_q <= cnt_q - CntW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign recoverValid     = recover_valid_q;
  assign recoverStackTop  = top_q;
  assign recoverQueueTail = tail_q;
  assign fetchStall       = fetch_stall_q;
  assign busy             = busy_q;
  assign dropCount        = drop_cnt_q;

endmodule

// File: doc/ras_recovery_sequencer.md
Name: ras_recovery_sequencer

Overview:
- Arbitrates RAS pointer-recovery requests from several backend sources (branch resolution, replay/flush units) and sequences them into the front-end return address stack.
- Picks the oldest request by ROB age, presents one registered recovery strobe with the checkpoint pointers, then holds fetch-side push/pop off for a fixed lockout.
- Younger recoveries arriving while one is in flight are discarded, because the older recovery squashes them. Older ones preempt.
- Sits between the backend recovery logic and the RAS recovery inputs (recover strobe, stackTopPtr, queueTailPtr).

Parameters:
NUM_SRC, 2, number of recovery requesters
RAS_ENTRY_NUM, 16, RAS entries; IDX_W = log2(RAS_ENTRY_NUM)
AGE_W, 7, ROB pointer width used as age
LOCK_CYCLES, 2, cycles fetchStall is held after the issue cycle (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
robHead  in  AGE_W  oldest ROB pointer; age reference
flushAll  in  1  full pipeline flush; recover to pointers 0/0, highest priority
srcValid  in  NUM_SRC  recovery request per source
srcAge  in  NUM_SRC*AGE_W  ROB pointer of the mispredicted branch, per source
srcStackTop  in  NUM_SRC*IDX_W  checkpointed stackTopPtr, per source
srcQueueTail  in  NUM_SRC*IDX_W  checkpointed queueTailPtr, per source
srcAck  out  NUM_SRC  combinational; request consumed this cycle (accepted or dropped)
recoverValid  out  1  registered one-cycle recovery strobe to the RAS
recoverStackTop  out  IDX_W  stackTopPtr to restore
recoverQueueTail  out  IDX_W  queueTailPtr to restore
fetchStall  out  1  blocks RAS push/pop while in ISSUE or LOCK
busy  out  1  state != IDLE
dropCount  out  16  saturating count of discarded requests

Behaviour:
- Reset (asynchronous): state=IDLE, recoverValid=0, recoverStackTop=0, recoverQueueTail=0, fetchStall=0, busy=0, dropCount=0, latched age=0, lock counter=0.
- Relative age: rel = (srcAge - robHead) mod 2^AGE_W. Smaller rel means older. Equal rel: lower source index wins.
- srcAck[i] = srcValid[i] in every state. Requests are never back-pressured. Sources deassert the cycle after ack.
- Candidate each cycle: oldest valid source. flushAll overrides any source; its candidate pointers are 0/0 and it is treated as older than everything.
- IDLE: on candidate, latch pointers and age (flush latches rel=0 plus a flush flag), then go to ISSUE. Non-winning valid sources in the same cycle are dropped (dropCount += their count).
- ISSUE (1 cycle): recoverValid=1, fetchStall=1, outputs hold the latched pointers. Next state is LOCK with counter=LOCK_CYCLES; if LOCK_CYCLES=0, next state is IDLE.
- LOCK: fetchStall=1. Counter decrements each cycle; at 1 → IDLE.
- Preemption rules in ISSUE and LOCK:
  - Candidate strictly older than latched (flush always wins, except flush vs latched flush): re-latch, go to ISSUE next cycle. Counter is reloaded on that ISSUE.
  - Otherwise the candidate is dropped.
  - All non-winners are dropped.
- Age comparisons use the current robHead each cycle. Latched age is stored as the raw ROB pointer, not the rel value.
- recoverValid is high for exactly one cycle per accepted request. Back-to-back preemption gives consecutive strobes with the newest pointers.
- Outside ISSUE, recoverStackTop/QueueTail keep their last value; they are only valid when qualified by recoverValid.
- dropCount saturates at 0xFFFF. Multiple drops in one cycle add together and clamp.
- Reset asserted mid-ISSUE/LOCK: immediate return to IDLE. The strobe is lost and fetchStall drops asynchronously.

Test Plan:
- IDLE, src0 valid, age=5, robHead=0, ptrs (3,7) → srcAck=01; next cycle recoverValid=1, outputs 3/7, fetchStall=1; then 2 LOCK cycles; busy low on cycle 4.
- Same cycle: src0 age=10, src1 age=4, robHead=0 → src1 pointers issued, dropCount=1.
- Wrap: robHead=120, src0 age=2 (rel 10), src1 age=125 (rel 5) → src1 wins.
- In LOCK after age 20: src0 age=15 arrives → second recoverValid with new pointers, counter reloaded. src0 age=30 arrives instead → dropped, no strobe, dropCount +1.
- flushAll during LOCK with src1 valid → recover 0/0 issued, src1 dropped.
- LOCK_CYCLES=0 → ISSUE is followed directly by IDLE. Async rst during ISSUE → all outputs 0 in the same cycle.
